// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request feeding a DEPTH-entry decode queue.
// Optional build macro FETCH_QUEUE_PERF_EN adds the perf_starve decode-starvation counter.
module fetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_take,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0] perf_starve
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            req_q;
   logic [31:0]     addr_q;
   logic [31:0]     req_pc_q;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];
   logic            full;
   logic            push;
   logic            pop;

   assign full = (count_q == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (pc_take) state_d = WAIT;
         WAIT: begin
            if (imem_ack)   state_d = IDLE;
            else if (flush) state_d = DROP;
         end
         DROP: if (imem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_take = 1'b0;
      if (state_q == IDLE && !flush && !rst && !full) pc_take = 1'b1;
   end

   // An ack in IDLE (e.g. left over from before a reset) is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q    <= 1'b0;
         addr_q   <= 32'd0;
         req_pc_q <= 32'd0;
      end else if (pc_take) begin
         req_q    <= 1'b1;
         addr_q   <= {pc_in[31:2], 2'b00};
         req_pc_q <= pc_in;
      end else if (imem_ack && state_q != IDLE) begin
         req_q    <= 1'b0;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;

   assign push = (state_q == WAIT) && imem_ack && !flush;
   assign pop  = dec_valid && dec_ready && !flush;

   // DEPTH is a power of two, so pointer increments wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= 32'd0;
            instr_mem_q[i] <= 32'd0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   assign dec_valid = (count_q != '0);
   assign dec_instr = instr_mem_q[rd_ptr_q];
   assign dec_pc    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] starve_q;

   always_ff @(posedge clk) begin
      if (rst)                         starve_q <= 32'd0;
      else if (dec_ready && !dec_valid) starve_q <= starve_q + 32'd1;
   end

   assign perf_starve = starve_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed sequences, an alignment vector table,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_take;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_starve;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .pc_take    (pc_take),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dec_valid  (dec_valid),
      .dec_instr  (dec_instr),
      .dec_pc     (dec_pc),
      .dec_ready  (dec_ready)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .perf_starve(perf_starve)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; dec_ready = 1'b0;
      nxt();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      logic [31:0] addr;
   } vec_t;

   vec_t vt[5];

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic [63:0] mq[$];
   bit          m_out;
   bit          m_drop;
   logic [31:0] m_pc;
   bit          exp_take;
   int          pulses;

   initial begin
      vt[0] = '{32'h0000_0106, 32'h0BAD_F00D, 32'h0000_0104};
      vt[1] = '{32'h0000_0107, 32'h1111_2222, 32'h0000_0104};
      vt[2] = '{32'hFFFF_FFFF, 32'h3333_4444, 32'hFFFF_FFFC};
      vt[3] = '{32'h0000_0000, 32'h5555_6666, 32'h0000_0000};
      vt[4] = '{32'h1234_5679, 32'h7777_8888, 32'h1234_5678};

      rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
      dec_ready = 1'b1; pc_in = 32'h100;
      nxt(); nxt();
      #2;
      chk("rst_pc_take", pc_take, 1'b0);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      nxt();

      // Basic issue / ack / decode latency
      rst = 1'b0; pc_in = 32'h100; dec_ready = 1'b1;
      #2 chk("lat_take_n", pc_take, 1'b1);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      #2;
      chk("lat_req_n1", imem_req, 1'b1);
      chk("lat_addr_n1", imem_addr, 32'h100);
      chk("lat_take_n1", pc_take, 1'b0);
      nxt();
      imem_ack = 1'b0;
      #2;
      chk("lat_valid_n2", dec_valid, 1'b1);
      chk("lat_pc_n2", dec_pc, 32'h100);
      chk("lat_instr_n2", dec_instr, 32'h1234_5678);
      chk("lat_req_n2", imem_req, 1'b0);

      // Backpressure fills the queue, then drains in order
      do_reset();
      dec_ready = 1'b0; pulses = 0;
      for (int i = 0; i < 12; i++) begin
         pc_in      = 32'h1000 + 32'(4 * pulses);
         imem_ack   = imem_req;
         imem_rdata = imem_addr ^ K;
         #2;
         if (pc_take) pulses++;
         nxt();
      end
      imem_ack = 1'b0;
      #2;
      chk("full_pulses", 32'(pulses), 32'd2);
      chk("full_take", pc_take, 1'b0);
      chk("full_req", imem_req, 1'b0);
      chk("full_valid", dec_valid, 1'b1);
      chk("full_pc0", dec_pc, 32'h1000);
      chk("full_instr0", dec_instr, 32'h1000 ^ K);
      nxt();
      chk("full_hold_pc", dec_pc, 32'h1000);
      dec_ready = 1'b1;
      #2 chk("full_take_pop", pc_take, 1'b0);
      nxt();
      #2;
      chk("full_pc1", dec_pc, 32'h1004);
      chk("full_instr1", dec_instr, 32'h1004 ^ K);

      // Flush while a request is in flight: result dropped
      do_reset();
      dec_ready = 1'b1; pc_in = 32'h200;
      #2 chk("drop_take", pc_take, 1'b1);
      nxt();
      flush = 1'b1;
      #2 chk("drop_take_flush", pc_take, 1'b0);
      nxt();
      flush = 1'b0;
      #2;
      chk("drop_req_a", imem_req, 1'b1);
      chk("drop_take_a", pc_take, 1'b0);
      chk("drop_valid_a", dec_valid, 1'b0);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #2;
      chk("drop_req_b", imem_req, 1'b1);
      chk("drop_take_b", pc_take, 1'b0);
      nxt();
      imem_ack = 1'b0;
      #2;
      chk("drop_req_c", imem_req, 1'b0);
      chk("drop_valid_c", dec_valid, 1'b0);
      chk("drop_take_c", pc_take, 1'b1);

      // Flush coincident with ack while an entry is queued
      do_reset();
      dec_ready = 1'b0; pc_in = 32'h300;
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      nxt();
      imem_ack = 1'b0; pc_in = 32'h304;
      #2 chk("fa_take", pc_take, 1'b1);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; flush = 1'b1;
      #2 chk("fa_valid_pre", dec_valid, 1'b1);
      nxt();
      imem_ack = 1'b0; flush = 1'b0; dec_ready = 1'b1; pc_in = 32'h400;
      #2;
      chk("fa_valid_post", dec_valid, 1'b0);
      chk("fa_req_post", imem_req, 1'b0);
      chk("fa_take_post", pc_take, 1'b1);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
      nxt();
      imem_ack = 1'b0;
      #2;
      chk("fa_valid_new", dec_valid, 1'b1);
      chk("fa_pc_new", dec_pc, 32'h400);
      chk("fa_instr_new", dec_instr, 32'h55);

      // Reset mid-request, late ack must be ignored
      do_reset();
      pc_in = 32'h500;
      nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0000; pc_in = 32'h600;
      #2 chk("late_req", imem_req, 1'b0);
      nxt();
      imem_ack = 1'b0;
      #2;
      chk("late_valid", dec_valid, 1'b0);
      chk("late_req2", imem_req, 1'b1);
      chk("late_addr", imem_addr, 32'h600);

      // Alignment table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         dec_ready = 1'b1; pc_in = vt[v].pc;
         #2 chk("tbl_take", pc_take, 1'b1);
         nxt();
         chk("tbl_addr", imem_addr, vt[v].addr);
         imem_ack = 1'b1; imem_rdata = vt[v].rdata;
         nxt();
         imem_ack = 1'b0;
         #2;
         chk("tbl_pc", dec_pc, vt[v].pc);
         chk("tbl_instr", dec_instr, vt[v].rdata);
      end

`ifdef FETCH_QUEUE_PERF_EN
      do_reset();
      dec_ready = 1'b1; flush = 1'b1;
      for (int i = 0; i < 5; i++) nxt();
      chk("perf_count", perf_starve, 32'd5);
      rst = 1'b1;
      nxt();
      chk("perf_reset", perf_starve, 32'd0);
      rst = 1'b0; flush = 1'b0; dec_ready = 1'b0;
`endif

      // Randomized run against reference model
      do_reset();
      mq.delete(); m_out = 1'b0; m_drop = 1'b0; m_pc = 32'd0;
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(199) == 0);
         flush      = ($urandom_range(11) == 0);
         dec_ready  = ($urandom_range(2) != 0);
         imem_ack   = m_out && ($urandom_range(1) == 1);
         imem_rdata = $urandom;
         pc_in      = $urandom;
         exp_take   = !rst && !m_out && !flush && (mq.size() < DEPTH);
         #2;
         chk("rnd_take", pc_take, exp_take);
         chk("rnd_valid", dec_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("rnd_pc", dec_pc, mq[0][63:32]);
            chk("rnd_instr", dec_instr, mq[0][31:0]);
         end
         chk("rnd_req", imem_req, m_out);
         if (m_out) chk("rnd_addr", imem_addr, m_pc & ~32'd3);
         if (rst) begin
            mq.delete(); m_out = 1'b0; m_drop = 1'b0;
         end else begin
            if (flush) mq.delete();
            else begin
               if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
               if (m_out && !m_drop && imem_ack) mq.push_back({m_pc, imem_rdata});
            end
            if (m_out) begin
               if (imem_ack)   m_out = 1'b0;
               else if (flush) m_drop = 1'b1;
            end else if (exp_take) begin
               m_out = 1'b1; m_drop = 1'b0; m_pc = pc_in;
            end
         end
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
